// File: rtl/aes_key_expander_if.sv
// Bundles the key-load handshake and round-key read port of the AES key expander.
// The master side loads keys and reads round keys; the slave side is the expander.
interface aes_key_expander_if;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic         busy;
    logic         done;
    logic         err;
    logic         rd_en;
    logic [3:0]   rd_round;
    logic         rd_valid;
    logic         rd_err;
    logic [127:0] rd_key;

    modport master (
        output start, key_len, key_in, rd_en, rd_round,
        input  busy, done, err, rd_valid, rd_err, rd_key
    );

    modport slave (
        input  start, key_len, key_in, rd_en, rd_round,
        output busy, done, err, rd_valid, rd_err, rd_key
    );
endinterface

// File: rtl/aes_key_expander.sv
// Iterative AES-128/192/256 key schedule: one 32-bit word per clock into internal storage,
// with a registered round-key read port usable while expansion is still running.
module aes_key_expander #(
    parameter int WORD          = 32,
    parameter int MAX_KEY_WIDTH = 256,
    parameter int SBOX_INST     = 4
) (
    input logic               clk,
    input logic               reset,
    aes_key_expander_if.slave bus
);

    localparam int NR_MAX = (MAX_KEY_WIDTH >= 256) ? 14 : (MAX_KEY_WIDTH >= 192) ? 12 : 10;
    localparam int DEPTH  = 4 * (NR_MAX + 1);

    if (WORD != 32) begin : g_word_check
        $error("aes_key_expander: WORD must be 32");
    end
    if (MAX_KEY_WIDTH != 128 && MAX_KEY_WIDTH != 192 && MAX_KEY_WIDTH != 256) begin : g_width_check
        $error("aes_key_expander: MAX_KEY_WIDTH must be 128, 192 or 256");
    end
    if (SBOX_INST != 4) begin : g_sbox_check
        $error("aes_key_expander: SBOX_INST must be 4");
    end

    // Forward S-box, byte 0x00 at the left end of the constant.
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXPAND,
        DONE
    } state_t;

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[8*int'(b) +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t      state;
    state_t      state_next;
    logic [1:0]  klen;
    logic [5:0]  count;
    logic [2:0]  mod_cnt;
    logic [7:0]  rcon;
    logic        busy;
    logic        done;
    logic        err;
    logic        rd_valid;
    logic        rd_err;
    logic [127:0] rd_key;

    logic [31:0] words [DEPTH];

    logic [5:0]  nk;
    logic [2:0]  nk_m1;
    logic [3:0]  nr;
    logic [5:0]  total;
    logic        key_ok;
    logic        idle_like;
    logic        accept;
    logic        reject;
    logic        last_word;
    logic [31:0] prev_word;
    logic [31:0] back_word;
    logic [31:0] temp_word;
    logic [31:0] new_word;
    logic [5:0]  rd_base;
    logic        rd_avail;

    // Geometry of the latched key, plus legality of the key length being offered now.
    always_comb begin
        nk     = 6'd8;
        nk_m1  = 3'd7;
        nr     = 4'd14;
        total  = 6'd60;
        key_ok = 1'b0;
        case (klen)
            2'b00: begin
                nk    = 6'd4;
                nk_m1 = 3'd3;
                nr    = 4'd10;
                total = 6'd44;
            end
            2'b01: begin
                nk    = 6'd6;
                nk_m1 = 3'd5;
                nr    = 4'd12;
                total = 6'd52;
            end
            default: ;
        endcase
        case (bus.key_len)
            2'b00:   key_ok = (MAX_KEY_WIDTH >= 128);
            2'b01:   key_ok = (MAX_KEY_WIDTH >= 192);
            2'b10:   key_ok = (MAX_KEY_WIDTH >= 256);
            default: key_ok = 1'b0;
        endcase
    end

    assign idle_like = (state == IDLE) || (state == DONE);
    assign accept    = idle_like && bus.start && key_ok;
    assign reject    = idle_like && bus.start && !key_ok;
    assign last_word = (count == total - 6'd1);

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (accept) state_next = LOAD;
            LOAD:       state_next = EXPAND;
            EXPAND:     if (last_word) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    // count doubles as the schedule index i while expanding; mod_cnt tracks i mod Nk.
    always_comb begin
        prev_word = words[count - 6'd1];
        back_word = words[count - nk];
        temp_word = prev_word;
        if (mod_cnt == 3'd0) begin
            temp_word = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon, 24'h000000};
        end else if (nk == 6'd8 && mod_cnt == 3'd4) begin
            temp_word = sub_word(prev_word);
        end
        new_word = back_word ^ temp_word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            klen    <= 2'b00;
            count   <= 6'd0;
            mod_cnt <= 3'd0;
            rcon    <= 8'h00;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state <= state_next;
            err   <= reject;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        klen  <= bus.key_len;
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        count <= 6'd0;
                    end
                end
                LOAD: begin
                    count   <= nk;
                    mod_cnt <= 3'd0;
                    rcon    <= 8'h01;
                end
                EXPAND: begin
                    count   <= count + 6'd1;
                    mod_cnt <= (mod_cnt == nk_m1) ? 3'd0 : mod_cnt + 3'd1;
                    if (mod_cnt == 3'd0) rcon <= xtime(rcon);
                    if (last_word) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Schedule storage carries no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            for (int k = 0; k < 8; k++) begin
                if (6'(k) < nk) words[6'(k)] <= bus.key_in[255 - 32*k -: 32];
            end
        end else if (state == EXPAND) begin
            words[count] <= new_word;
        end
    end

    assign rd_base  = {bus.rd_round, 2'b00};
    assign rd_avail = (bus.rd_round <= nr) && ({1'b0, count} >= ({1'b0, rd_base} + 7'd4));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            rd_key   <= 128'h0;
        end else begin
            rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                if (rd_avail) begin
                    rd_err <= 1'b0;
                    rd_key <= {words[rd_base], words[rd_base + 6'd1],
                               words[rd_base + 6'd2], words[rd_base + 6'd3]};
                end else begin
                    rd_err <= 1'b1;
                    rd_key <= 128'h0;
                end
            end
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.err      = err;
    assign bus.rd_valid = rd_valid;
    assign bus.rd_err   = rd_err;
    assign bus.rd_key   = rd_key;

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed FIPS-197 key-schedule vectors against aes_key_expander, plus control, streaming
// read, mid-run reset and a reduced-width build.
module tb_aes_key_expander;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    aes_key_expander_if ifc ();
    aes_key_expander_if ifc_small ();

    aes_key_expander dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    aes_key_expander #(.MAX_KEY_WIDTH(128)) dut_small (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc_small.slave)
    );

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    localparam logic [127:0] R128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] R256_1  = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

    int check_count = 0;
    int pass_count  = 0;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        check_count++;
        if (observed === expected) pass_count++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    endtask

    task automatic readRound(input logic [3:0] r, input string tag,
                             input logic exp_err, input logic [127:0] exp_key);
        @(negedge clk);
        ifc.rd_en    = 1'b1;
        ifc.rd_round = r;
        @(negedge clk);
        ifc.rd_en = 1'b0;
        checkOutput({tag, "_flags"}, {126'h0, ifc.rd_valid, ifc.rd_err}, {126'h0, 1'b1, exp_err});
        checkOutput({tag, "_key"}, ifc.rd_key, exp_key);
    endtask

    // Starts an expansion and counts clock edges until done; optionally re-asserts start mid-run.
    task automatic applyStimulus(input logic [1:0] kl, input logic [255:0] key, input int inject_at,
                                 input int exp_lat, input string tag);
        int   n;
        logic err_seen;
        @(negedge clk);
        ifc.start   = 1'b1;
        ifc.key_len = kl;
        ifc.key_in  = key;
        n        = 0;
        err_seen = 1'b0;
        do begin
            @(negedge clk);
            ifc.start = 1'b0;
            n++;
            err_seen |= ifc.err;
            if (n == inject_at) begin
                ifc.start   = 1'b1;
                ifc.key_len = 2'b00;
                ifc.key_in  = '1;
            end
        end while (!ifc.done && n < 200);
        checkOutput({tag, "_latency"}, 128'(n), 128'(exp_lat));
        checkOutput({tag, "_no_err"}, {127'h0, err_seen}, 128'h0);
    endtask

    initial begin
        int   n;
        logic exp_err;

        ifc.start          = 1'b0;
        ifc.key_len        = 2'b00;
        ifc.key_in         = '0;
        ifc.rd_en          = 1'b0;
        ifc.rd_round       = 4'd0;
        ifc_small.start    = 1'b0;
        ifc_small.key_len  = 2'b00;
        ifc_small.key_in   = '0;
        ifc_small.rd_en    = 1'b0;
        ifc_small.rd_round = 4'd0;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_flags", {123'h0, ifc.busy, ifc.done, ifc.err, ifc.rd_valid, ifc.rd_err}, 128'h0);
        checkOutput("reset_key", ifc.rd_key, 128'h0);
        reset = 1'b0;
        readRound(4'd0, "reset_read", 1'b1, 128'h0);

        // Streaming read of round 1 from the start cycle of an AES-128 expansion.
        @(negedge clk);
        ifc.start    = 1'b1;
        ifc.key_len  = 2'b00;
        ifc.key_in   = KEY128;
        ifc.rd_en    = 1'b1;
        ifc.rd_round = 4'd1;
        n = 0;
        do begin
            @(negedge clk);
            ifc.start = 1'b0;
            n++;
            if (n <= 10) begin
                exp_err = (n <= 6);
                checkOutput($sformatf("stream_flags_%0d", n), {126'h0, ifc.rd_valid, ifc.rd_err},
                            {126'h0, 1'b1, exp_err});
                checkOutput($sformatf("stream_key_%0d", n), ifc.rd_key, exp_err ? 128'h0 : R128_1);
            end
        end while (!ifc.done && n < 200);
        ifc.rd_en = 1'b0;
        checkOutput("aes128_latency", 128'(n), 128'd42);
        checkOutput("aes128_busy_done", {126'h0, ifc.busy, ifc.done}, 128'h1);

        readRound(4'd0, "aes128_r0", 1'b0, R128_0);
        readRound(4'd1, "aes128_r1", 1'b0, R128_1);
        readRound(4'd10, "aes128_r10", 1'b0, R128_10);
        readRound(4'd11, "aes128_r11", 1'b1, 128'h0);

        // Illegal key length from DONE: one err pulse, state and done untouched.
        @(negedge clk);
        ifc.start   = 1'b1;
        ifc.key_len = 2'b11;
        @(negedge clk);
        ifc.start = 1'b0;
        checkOutput("keylen11_pulse", {125'h0, ifc.err, ifc.busy, ifc.done}, 128'h5);
        @(negedge clk);
        checkOutput("keylen11_after", {125'h0, ifc.err, ifc.busy, ifc.done}, 128'h1);

        // AES-192 with a stray start in the middle of expansion.
        applyStimulus(2'b01, KEY192, 10, 48, "aes192");
        readRound(4'd12, "aes192_r12", 1'b0, R192_12);
        readRound(4'd13, "aes192_r13", 1'b1, 128'h0);

        applyStimulus(2'b10, KEY256, 0, 54, "aes256");
        readRound(4'd1, "aes256_r1", 1'b0, R256_1);
        readRound(4'd14, "aes256_r14", 1'b0, R256_14);
        readRound(4'd15, "aes256_r15", 1'b1, 128'h0);

        // Reset in the middle of an AES-256 expansion, then a clean AES-128 run.
        @(negedge clk);
        ifc.start   = 1'b1;
        ifc.key_len = 2'b10;
        ifc.key_in  = KEY256;
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("midreset_flags", {123'h0, ifc.busy, ifc.done, ifc.err, ifc.rd_valid, ifc.rd_err}, 128'h0);
        checkOutput("midreset_key", ifc.rd_key, 128'h0);
        @(negedge clk);
        reset = 1'b0;
        readRound(4'd0, "midreset_read", 1'b1, 128'h0);
        applyStimulus(2'b00, KEY128, 0, 42, "aes128_again");
        readRound(4'd10, "aes128_again_r10", 1'b0, R128_10);

        // A build limited to 128-bit keys rejects longer key lengths.
        @(negedge clk);
        ifc_small.start   = 1'b1;
        ifc_small.key_len = 2'b10;
        ifc_small.key_in  = KEY256;
        @(negedge clk);
        ifc_small.start = 1'b0;
        checkOutput("small_reject", {126'h0, ifc_small.err, ifc_small.busy}, 128'h2);
        @(negedge clk);
        ifc_small.start   = 1'b1;
        ifc_small.key_len = 2'b00;
        ifc_small.key_in  = KEY128;
        @(negedge clk);
        ifc_small.start = 1'b0;
        checkOutput("small_accept", {126'h0, ifc_small.err, ifc_small.busy}, 128'h1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
